// File: rtl/kbd_scan_decoder.sv
// PS/2 Set-2 scan decoder: pops bytes from ps2_keyboard, tracks one held
// key, maps it to ASCII, counts presses and drives six 7-segment digits.
module kbd_scan_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic             key_ext,
  output logic [7:0]       scancode,
  output logic [7:0]       ascii,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_err,
  output logic [7:0]       seg0,
  output logic [7:0]       seg1,
  output logic [7:0]       seg2,
  output logic [7:0]       seg3,
  output logic [7:0]       seg4,
  output logic [7:0]       seg5
);

  typedef enum logic {
    FETCH,
    WAIT
  } pop_e;

  typedef enum logic [1:0] {
    BASE,
    EXT,
    BRK,
    EXT_BRK
  } dec_e;

  pop_e       pop_q, pop_d;
  dec_e       dec_q, dec_d;
  logic [7:0] byte_q;
  logic       byte_vld;
  logic       mk, bk, ext;
  logic       same;

  function automatic logic [7:0] to_ascii(input logic [7:0] c);
    logic [7:0] a;
    case (c)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63;
      8'h23: a = 8'h64; 8'h24: a = 8'h65; 8'h2B: a = 8'h66;
      8'h34: a = 8'h67; 8'h33: a = 8'h68; 8'h43: a = 8'h69;
      8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F;
      8'h4D: a = 8'h70; 8'h15: a = 8'h71; 8'h2D: a = 8'h72;
      8'h1B: a = 8'h73; 8'h2C: a = 8'h74; 8'h3C: a = 8'h75;
      8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32;
      8'h26: a = 8'h33; 8'h25: a = 8'h34; 8'h2E: a = 8'h35;
      8'h36: a = 8'h36; 8'h3D: a = 8'h37; 8'h3E: a = 8'h38;
      8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h03; 4'h1: s = 8'h9F; 4'h2: s = 8'h25;
      4'h3: s = 8'h0D; 4'h4: s = 8'h99; 4'h5: s = 8'h49;
      4'h6: s = 8'h41; 4'h7: s = 8'h1F; 4'h8: s = 8'h01;
      4'h9: s = 8'h09; 4'hA: s = 8'h11; 4'hB: s = 8'hC1;
      4'hC: s = 8'h63; 4'hD: s = 8'h85; 4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    pop_d      = pop_q;
    nextdata_n = 1'b1;
    unique case (pop_q)
      FETCH: begin
        if (ps2_ready) begin
          nextdata_n = 1'b0;
          pop_d      = WAIT;
        end
      end
      WAIT: pop_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pop_q    <= FETCH;
      byte_q   <= 8'h00;
      byte_vld <= 1'b0;
    end else begin
      pop_q    <= pop_d;
      byte_vld <= !nextdata_n;
      if (!nextdata_n) byte_q <= ps2_data;
    end
  end

  // Prefix tracker: E0/F0 steer the state, the final byte is classified.
  always_comb begin
    dec_d = dec_q;
    mk    = 1'b0;
    bk    = 1'b0;
    ext   = 1'b0;
    if (byte_vld) begin
      unique case (dec_q)
        BASE: begin
          if (byte_q == 8'hE0) dec_d = EXT;
          else if (byte_q == 8'hF0) dec_d = BRK;
          else if (byte_q != 8'hAA && byte_q != 8'hFA &&
                   byte_q != 8'hEE && byte_q != 8'hE1) mk = 1'b1;
        end
        EXT: begin
          ext = 1'b1;
          if (byte_q == 8'hF0) dec_d = EXT_BRK;
          else if (byte_q != 8'hE0) begin
            mk    = 1'b1;
            dec_d = BASE;
          end
        end
        BRK: begin
          dec_d = BASE;
          bk    = (byte_q != 8'hE0 && byte_q != 8'hF0);
        end
        EXT_BRK: begin
          ext   = 1'b1;
          dec_d = BASE;
          bk    = (byte_q != 8'hE0 && byte_q != 8'hF0);
        end
      endcase
    end
  end

  assign same = ({ext, byte_q} == {key_ext, scancode});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dec_q     <= BASE;
      key_valid <= 1'b0;
      key_ext   <= 1'b0;
      scancode  <= 8'h00;
      ascii     <= 8'h00;
      press_cnt <= '0;
      ovf_err   <= 1'b0;
    end else begin
      dec_q <= dec_d;
      if (ps2_overflow) ovf_err <= 1'b1;
      if (mk && !(key_valid && same)) begin
        key_valid <= 1'b1;
        key_ext   <= ext;
        scancode  <= byte_q;
        ascii     <= ext ? 8'h00 : to_ascii(byte_q);
        press_cnt <= press_cnt + CNT_W'(1);
      end else if (bk && same) begin
        key_valid <= 1'b0;
      end
    end
  end

  assign seg0 = key_valid ? hex7(scancode[3:0]) : 8'hFF;
  assign seg1 = key_valid ? hex7(scancode[7:4]) : 8'hFF;
  assign seg2 = key_valid ? hex7(ascii[3:0]) : 8'hFF;
  assign seg3 = key_valid ? hex7(ascii[7:4]) : 8'hFF;
  assign seg4 = hex7(press_cnt[3:0]);
  assign seg5 = hex7(press_cnt[7:4]);

endmodule
